// File: rtl/kl_arbiter_nby1.sv
// kl_arbiter_nby1: N-to-1 round-robin request arbiter and dstid-decoded
// response router for the KL bus. A stalled grant is locked until accepted.
// Optional macro KL_ARB_OUTSTANDING_LIMIT_EN adds per-port outstanding-request
// counters that make a port ineligible once it reaches MAX_OUTSTANDING.
module kl_arbiter_nby1 #(
  parameter int N_PORTS         = 2,
  parameter int SRCID_BASE      = 0,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [32*N_PORTS-1:0]  up_req_addr,
  input  logic [N_PORTS-1:0]     up_req_wen,
  input  logic [64*N_PORTS-1:0]  up_req_wdata,
  input  logic [8*N_PORTS-1:0]   up_req_wmask,
  input  logic [3*N_PORTS-1:0]   up_req_size,
  input  logic [N_PORTS-1:0]     up_req_valid,
  output logic [N_PORTS-1:0]     up_req_ready,
  output logic [64*N_PORTS-1:0]  up_resp_rdata,
  output logic [N_PORTS-1:0]     up_resp_valid,
  input  logic [N_PORTS-1:0]     up_resp_ready,
  output logic [31:0]            dn_req_addr,
  output logic                   dn_req_wen,
  output logic [63:0]            dn_req_wdata,
  output logic [7:0]             dn_req_wmask,
  output logic [2:0]             dn_req_size,
  output logic [4:0]             dn_req_srcid,
  output logic                   dn_req_valid,
  input  logic                   dn_req_ready,
  input  logic [63:0]            dn_resp_rdata,
  input  logic [2:0]             dn_resp_size,
  input  logic [4:0]             dn_resp_dstid,
  input  logic                   dn_resp_valid,
  output logic                   dn_resp_ready
);

  localparam int PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  logic [PW-1:0]      rr_ptr;
  logic               lock;
  logic [PW-1:0]      lock_port;
  logic [PW-1:0]      scan_idx;
  logic               scan_found;
  logic [PW-1:0]      cand;
  logic [PW-1:0]      grant_idx;
  logic               grant_valid;
  logic               req_fire;
  logic [N_PORTS-1:0] eligible;

  // The response size is not needed for routing; it is only carried by masters.
  logic unused_resp_size;
  assign unused_resp_size = ^dn_resp_size;

  // Round-robin scan: first valid and eligible port at or after rr_ptr, wrapping.
  always_comb begin
    scan_found = 1'b0;
    scan_idx   = '0;
    cand       = '0;
    for (int k = 0; k < N_PORTS; k++) begin
      cand = PW'((int'(rr_ptr) + k) % N_PORTS);
      if (!scan_found && up_req_valid[cand] && eligible[cand]) begin
        scan_found = 1'b1;
        scan_idx   = cand;
      end
    end
  end

  // A stalled request keeps the bus regardless of other requesters or the pointer.
  assign grant_idx    = lock ? lock_port : scan_idx;
  assign grant_valid  = lock ? up_req_valid[lock_port] : scan_found;
  assign dn_req_valid = rst_n & grant_valid;
  assign req_fire     = dn_req_valid & dn_req_ready;
  assign dn_req_srcid = 5'(SRCID_BASE + int'(grant_idx));

  // Mux the granted port's payload onto the downstream request.
  always_comb begin
    dn_req_addr  = up_req_addr[31:0];
    dn_req_wen   = up_req_wen[0];
    dn_req_wdata = up_req_wdata[63:0];
    dn_req_wmask = up_req_wmask[7:0];
    dn_req_size  = up_req_size[2:0];
    for (int i = 0; i < N_PORTS; i++) begin
      if (grant_idx == PW'(i)) begin
        dn_req_addr  = up_req_addr[i*32 +: 32];
        dn_req_wen   = up_req_wen[i];
        dn_req_wdata = up_req_wdata[i*64 +: 64];
        dn_req_wmask = up_req_wmask[i*8 +: 8];
        dn_req_size  = up_req_size[i*3 +: 3];
      end
    end
  end

  // Only the granted port sees ready, and only when the downstream accepts.
  always_comb begin
    up_req_ready = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      up_req_ready[i] = req_fire && (grant_idx == PW'(i));
    end
  end

  // Decode dstid back to a port; unknown ids are sunk so the bus never wedges.
  always_comb begin
    up_resp_rdata = {N_PORTS{dn_resp_rdata}};
    up_resp_valid = '0;
    dn_resp_ready = rst_n;
    for (int i = 0; i < N_PORTS; i++) begin
      if (dn_resp_dstid == 5'(SRCID_BASE + i)) begin
        up_resp_valid[i] = rst_n & dn_resp_valid;
        dn_resp_ready    = rst_n & up_resp_ready[i];
      end
    end
  end

  // Advance the pointer past each accepted port; lock onto a stalled grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr    <= '0;
      lock      <= 1'b0;
      lock_port <= '0;
    end else if (req_fire) begin
      rr_ptr <= PW'((int'(grant_idx) + 1) % N_PORTS);
      lock   <= 1'b0;
    end else if (dn_req_valid) begin
      lock      <= 1'b1;
      lock_port <= grant_idx;
    end
  end

`ifdef KL_ARB_OUTSTANDING_LIMIT_EN
  for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_outstanding
    logic [3:0] count;
    logic       inc;
    logic       dec;

    assign inc = up_req_ready[gi];
    assign dec = up_resp_valid[gi] & up_resp_ready[gi];

    // Track requests in flight per port; simultaneous accept and response cancel.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        count <= '0;
      end else if (inc && !dec && count != 4'hF) begin
        count <= count + 4'd1;
      end else if (dec && !inc && count != 4'h0) begin
        count <= count - 4'd1;
      end
    end

    assign eligible[gi] = (count != 4'(MAX_OUTSTANDING));
  end
`else
  assign eligible = '1;
  logic [3:0] unused_max_outstanding;
  assign unused_max_outstanding = 4'(MAX_OUTSTANDING);
`endif

endmodule

// File: tb/tb_kl_arbiter_nby1.sv
// tb_kl_arbiter_nby1: self-checking bench for kl_arbiter_nby1 using a vector
// table, hand-written corner sequences and randomized traffic compared
// against a rule-level reference model.
module tb_kl_arbiter_nby1;

  localparam int NP   = 4;
  localparam int MAXO = 2;
  localparam int NB   = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  logic [32*NP-1:0] up_req_addr;
  logic [NP-1:0]    up_req_wen;
  logic [64*NP-1:0] up_req_wdata;
  logic [8*NP-1:0]  up_req_wmask;
  logic [3*NP-1:0]  up_req_size;
  logic [NP-1:0]    up_req_valid;
  logic [NP-1:0]    up_req_ready;
  logic [64*NP-1:0] up_resp_rdata;
  logic [NP-1:0]    up_resp_valid;
  logic [NP-1:0]    up_resp_ready;
  logic [31:0]      dn_req_addr;
  logic             dn_req_wen;
  logic [63:0]      dn_req_wdata;
  logic [7:0]       dn_req_wmask;
  logic [2:0]       dn_req_size;
  logic [4:0]       dn_req_srcid;
  logic             dn_req_valid;
  logic             dn_req_ready;
  logic [63:0]      dn_resp_rdata;
  logic [2:0]       dn_resp_size;
  logic [4:0]       dn_resp_dstid;
  logic             dn_resp_valid;
  logic             dn_resp_ready;

  logic [32*NB-1:0] b_up_req_addr;
  logic [NB-1:0]    b_up_req_wen;
  logic [64*NB-1:0] b_up_req_wdata;
  logic [8*NB-1:0]  b_up_req_wmask;
  logic [3*NB-1:0]  b_up_req_size;
  logic [NB-1:0]    b_up_req_valid;
  logic [NB-1:0]    b_up_req_ready;
  logic [64*NB-1:0] b_up_resp_rdata;
  logic [NB-1:0]    b_up_resp_valid;
  logic [NB-1:0]    b_up_resp_ready;
  logic [31:0]      b_dn_req_addr;
  logic             b_dn_req_wen;
  logic [63:0]      b_dn_req_wdata;
  logic [7:0]       b_dn_req_wmask;
  logic [2:0]       b_dn_req_size;
  logic [4:0]       b_dn_req_srcid;
  logic             b_dn_req_valid;
  logic             b_dn_req_ready;
  logic [63:0]      b_dn_resp_rdata;
  logic [2:0]       b_dn_resp_size;
  logic [4:0]       b_dn_resp_dstid;
  logic             b_dn_resp_valid;
  logic             b_dn_resp_ready;

  kl_arbiter_nby1 #(.N_PORTS(NP), .SRCID_BASE(0), .MAX_OUTSTANDING(MAXO)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .up_req_addr(up_req_addr), .up_req_wen(up_req_wen), .up_req_wdata(up_req_wdata),
    .up_req_wmask(up_req_wmask), .up_req_size(up_req_size), .up_req_valid(up_req_valid),
    .up_req_ready(up_req_ready), .up_resp_rdata(up_resp_rdata), .up_resp_valid(up_resp_valid),
    .up_resp_ready(up_resp_ready), .dn_req_addr(dn_req_addr), .dn_req_wen(dn_req_wen),
    .dn_req_wdata(dn_req_wdata), .dn_req_wmask(dn_req_wmask), .dn_req_size(dn_req_size),
    .dn_req_srcid(dn_req_srcid), .dn_req_valid(dn_req_valid), .dn_req_ready(dn_req_ready),
    .dn_resp_rdata(dn_resp_rdata), .dn_resp_size(dn_resp_size), .dn_resp_dstid(dn_resp_dstid),
    .dn_resp_valid(dn_resp_valid), .dn_resp_ready(dn_resp_ready)
  );

  kl_arbiter_nby1 #(.N_PORTS(NB), .SRCID_BASE(4), .MAX_OUTSTANDING(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .up_req_addr(b_up_req_addr), .up_req_wen(b_up_req_wen), .up_req_wdata(b_up_req_wdata),
    .up_req_wmask(b_up_req_wmask), .up_req_size(b_up_req_size), .up_req_valid(b_up_req_valid),
    .up_req_ready(b_up_req_ready), .up_resp_rdata(b_up_resp_rdata), .up_resp_valid(b_up_resp_valid),
    .up_resp_ready(b_up_resp_ready), .dn_req_addr(b_dn_req_addr), .dn_req_wen(b_dn_req_wen),
    .dn_req_wdata(b_dn_req_wdata), .dn_req_wmask(b_dn_req_wmask), .dn_req_size(b_dn_req_size),
    .dn_req_srcid(b_dn_req_srcid), .dn_req_valid(b_dn_req_valid), .dn_req_ready(b_dn_req_ready),
    .dn_resp_rdata(b_dn_resp_rdata), .dn_resp_size(b_dn_resp_size), .dn_resp_dstid(b_dn_resp_dstid),
    .dn_resp_valid(b_dn_resp_valid), .dn_resp_ready(b_dn_resp_ready)
  );

  int checks = 0;
  int failures = 0;

  logic [31:0] p_addr  [NP];
  logic [63:0] p_wdata [NP];
  logic        p_wen   [NP];
  logic [7:0]  p_wmask [NP];
  logic [2:0]  p_size  [NP];

  int m_ptr;
  bit m_lock;
  int m_lock_port;
  int m_cnt [NP];

  typedef struct {
    logic [3:0] vld;
    logic       rdy;
    logic       rv;
    logic [4:0] dst;
    logic       exp_valid;
    logic [4:0] exp_srcid;
    logic [3:0] exp_ready;
    logic [3:0] exp_rv;
  } vec_t;

  vec_t tbl [16];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [NP-1:0] vld, input logic rdy, input logic rv,
                               input logic [4:0] dst, input logic [NP-1:0] urr, input logic [63:0] rdata);
    for (int i = 0; i < NP; i++) begin
      up_req_addr[i*32 +: 32]  = p_addr[i];
      up_req_wdata[i*64 +: 64] = p_wdata[i];
      up_req_wen[i]            = p_wen[i];
      up_req_wmask[i*8 +: 8]   = p_wmask[i];
      up_req_size[i*3 +: 3]    = p_size[i];
    end
    up_req_valid  = vld;
    dn_req_ready  = rdy;
    dn_resp_valid = rv;
    dn_resp_dstid = dst;
    up_resp_ready = urr;
    dn_resp_rdata = rdata;
    dn_resp_size  = 3'd3;
  endtask

  function automatic void modelReset();
    m_ptr = 0;
    m_lock = 1'b0;
    m_lock_port = 0;
    for (int i = 0; i < NP; i++) m_cnt[i] = 0;
  endfunction

  function automatic bit modelEligible(input int p);
`ifdef KL_ARB_OUTSTANDING_LIMIT_EN
    return m_cnt[p] < MAXO;
`else
    return (p >= 0);
`endif
  endfunction

  // One model-checked clock cycle on the N=4 instance.
  task automatic step(input logic [NP-1:0] vld, input logic rdy, input logic rv,
                      input logic [4:0] dst, input logic [NP-1:0] urr, output int accepted);
    int g;
    logic [NP-1:0] exp_ready;
    logic [NP-1:0] exp_rv;
    logic exp_drr;
    logic [63:0] rdata;
    @(negedge clk);
    rdata = {$urandom, $urandom};
    applyStimulus(vld, rdy, rv, dst, urr, rdata);
    g = -1;
    if (m_lock) begin
      if (vld[m_lock_port]) g = m_lock_port;
    end else begin
      for (int k = 0; k < NP; k++) begin
        int j;
        j = (m_ptr + k) % NP;
        if (g < 0 && vld[j] && modelEligible(j)) g = j;
      end
    end
    exp_ready = (g >= 0 && rdy) ? (NP'(1) << g) : '0;
    exp_rv = '0;
    exp_drr = 1'b1;
    if (int'(dst) < NP) begin
      exp_rv  = rv ? (NP'(1) << dst) : '0;
      exp_drr = urr[dst];
    end
    #1;
    checkOutput("dn_req_valid", 64'(dn_req_valid), 64'(g >= 0));
    if (g >= 0) begin
      checkOutput("dn_req_srcid", 64'(dn_req_srcid), 64'(g));
      checkOutput("dn_req_addr", 64'(dn_req_addr), 64'(p_addr[g]));
      checkOutput("dn_req_wdata", dn_req_wdata, p_wdata[g]);
      checkOutput("dn_req_wen", 64'(dn_req_wen), 64'(p_wen[g]));
      checkOutput("dn_req_wmask", 64'(dn_req_wmask), 64'(p_wmask[g]));
      checkOutput("dn_req_size", 64'(dn_req_size), 64'(p_size[g]));
    end
    checkOutput("up_req_ready", 64'(up_req_ready), 64'(exp_ready));
    checkOutput("up_resp_valid", 64'(up_resp_valid), 64'(exp_rv));
    checkOutput("dn_resp_ready", 64'(dn_resp_ready), 64'(exp_drr));
    if (exp_rv != '0) checkOutput("up_resp_rdata", up_resp_rdata[int'(dst)*64 +: 64], rdata);
    @(posedge clk);
    accepted = -1;
    if (g >= 0 && rdy) begin
      m_cnt[g]++;
      m_ptr = (g + 1) % NP;
      m_lock = 1'b0;
      accepted = g;
    end else if (g >= 0) begin
      m_lock = 1'b1;
      m_lock_port = g;
    end
    if (rv && int'(dst) < NP && urr[dst]) m_cnt[dst]--;
  endtask

  // Reset both instances with busy inputs to prove the outputs are gated.
  task automatic doReset();
    @(negedge clk);
    applyStimulus('1, 1'b1, 1'b1, 5'd0, '1, 64'h0);
    rst_n = 1'b0;
    modelReset();
    #1;
    checkOutput("reset dn_req_valid", 64'(dn_req_valid), 64'd0);
    checkOutput("reset up_req_ready", 64'(up_req_ready), 64'd0);
    checkOutput("reset up_resp_valid", 64'(up_resp_valid), 64'd0);
    checkOutput("reset dn_resp_ready", 64'(dn_resp_ready), 64'd0);
    @(posedge clk);
    #2;
    applyStimulus('0, 1'b0, 1'b0, 5'd0, '0, 64'h0);
    rst_n = 1'b1;
  endtask

  initial begin
    int acc;
    logic [NP-1:0] pend;
    logic [4:0] dst;
    logic rv;
    int p;

    $display("[TB] start");
    b_up_req_addr = '0; b_up_req_wen = '0; b_up_req_wdata = '0; b_up_req_wmask = '0;
    b_up_req_size = '0; b_up_req_valid = '0; b_up_resp_ready = '0; b_dn_req_ready = 1'b0;
    b_dn_resp_rdata = '0; b_dn_resp_size = '0; b_dn_resp_dstid = '0; b_dn_resp_valid = 1'b0;
    for (int i = 0; i < NP; i++) begin
      p_addr[i]  = 32'h1000_0000 + 32'(i * 16);
      p_wdata[i] = 64'hCAFE_0000_0000_0000 + 64'(i);
      p_wen[i]   = 1'(i);
      p_wmask[i] = 8'h0F << i;
      p_size[i]  = 3'(i + 1);
    end

    // vld, rdy, rv, dst | exp_valid, exp_srcid, exp_ready, exp_rv
    tbl[0]  = '{4'b0011, 1'b1, 1'b0, 5'd0, 1'b1, 5'd0, 4'b0001, 4'b0000};
    tbl[1]  = '{4'b0011, 1'b1, 1'b0, 5'd0, 1'b1, 5'd1, 4'b0010, 4'b0000};
    tbl[2]  = '{4'b0011, 1'b1, 1'b1, 5'd0, 1'b1, 5'd0, 4'b0001, 4'b0001};
    tbl[3]  = '{4'b0011, 1'b1, 1'b0, 5'd0, 1'b1, 5'd1, 4'b0010, 4'b0000};
    tbl[4]  = '{4'b0001, 1'b1, 1'b1, 5'd1, 1'b1, 5'd0, 4'b0001, 4'b0010};
    tbl[5]  = '{4'b1010, 1'b0, 1'b1, 5'd0, 1'b1, 5'd1, 4'b0000, 4'b0001};
    tbl[6]  = '{4'b1010, 1'b0, 1'b0, 5'd0, 1'b1, 5'd1, 4'b0000, 4'b0000};
    tbl[7]  = '{4'b1010, 1'b0, 1'b0, 5'd0, 1'b1, 5'd1, 4'b0000, 4'b0000};
    tbl[8]  = '{4'b1010, 1'b1, 1'b0, 5'd0, 1'b1, 5'd1, 4'b0010, 4'b0000};
    tbl[9]  = '{4'b1000, 1'b1, 1'b0, 5'd0, 1'b1, 5'd3, 4'b1000, 4'b0000};
    tbl[10] = '{4'b0000, 1'b1, 1'b1, 5'd7, 1'b0, 5'd0, 4'b0000, 4'b0000};
    tbl[11] = '{4'b0100, 1'b1, 1'b0, 5'd0, 1'b1, 5'd2, 4'b0100, 4'b0000};
    tbl[12] = '{4'b0100, 1'b1, 1'b1, 5'd2, 1'b1, 5'd2, 4'b0100, 4'b0100};
    tbl[13] = '{4'b0100, 1'b1, 1'b0, 5'd0, 1'b1, 5'd2, 4'b0100, 4'b0000};
    tbl[14] = '{4'b1001, 1'b1, 1'b0, 5'd0, 1'b1, 5'd3, 4'b1000, 4'b0000};
    tbl[15] = '{4'b1001, 1'b1, 1'b0, 5'd0, 1'b1, 5'd0, 4'b0001, 4'b0000};

    doReset();

    for (int r = 0; r < 16; r++) begin
      @(negedge clk);
      applyStimulus(tbl[r].vld, tbl[r].rdy, tbl[r].rv, tbl[r].dst, 4'hF, 64'h0123_4567_89AB_CDEF + 64'(r));
      #1;
      checkOutput($sformatf("tbl%0d dn_req_valid", r), 64'(dn_req_valid), 64'(tbl[r].exp_valid));
      if (tbl[r].exp_valid) begin
        checkOutput($sformatf("tbl%0d dn_req_srcid", r), 64'(dn_req_srcid), 64'(tbl[r].exp_srcid));
        checkOutput($sformatf("tbl%0d dn_req_addr", r), 64'(dn_req_addr), 64'(p_addr[tbl[r].exp_srcid[1:0]]));
      end
      checkOutput($sformatf("tbl%0d up_req_ready", r), 64'(up_req_ready), 64'(tbl[r].exp_ready));
      checkOutput($sformatf("tbl%0d up_resp_valid", r), 64'(up_resp_valid), 64'(tbl[r].exp_rv));
      checkOutput($sformatf("tbl%0d dn_resp_ready", r), 64'(dn_resp_ready), 64'd1);
    end

    // Outstanding limit: port 0 fills up, port 1 still served, a response frees port 0.
    doReset();
    step(4'b0001, 1'b1, 1'b0, 5'd0, 4'hF, acc);
    step(4'b0001, 1'b1, 1'b0, 5'd0, 4'hF, acc);
    step(4'b0001, 1'b1, 1'b0, 5'd0, 4'hF, acc);
    step(4'b0011, 1'b1, 1'b0, 5'd0, 4'hF, acc);
    step(4'b0001, 1'b1, 1'b1, 5'd0, 4'hF, acc);
    step(4'b0001, 1'b1, 1'b0, 5'd0, 4'hF, acc);

    // Reset while stalled drops the lock; port 0 then wins a tie.
    doReset();
    step(4'b0010, 1'b0, 1'b0, 5'd0, 4'hF, acc);
    @(negedge clk);
    applyStimulus(4'b0011, 1'b0, 1'b1, 5'd0, 4'hF, 64'h55);
    #2;
    rst_n = 1'b0;
    modelReset();
    #1;
    checkOutput("midstall dn_req_valid", 64'(dn_req_valid), 64'd0);
    checkOutput("midstall up_req_ready", 64'(up_req_ready), 64'd0);
    checkOutput("midstall up_resp_valid", 64'(up_resp_valid), 64'd0);
    checkOutput("midstall dn_resp_ready", 64'(dn_resp_ready), 64'd0);
    @(posedge clk);
    #2;
    applyStimulus('0, 1'b0, 1'b0, 5'd0, '0, 64'h0);
    rst_n = 1'b1;
    step(4'b0011, 1'b1, 1'b0, 5'd0, 4'hF, acc);

    // Randomized traffic with masters that hold valid until accepted.
    doReset();
    pend = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NP; i++) begin
        if (!pend[i] && ($urandom % 3 == 0)) begin
          pend[i]    = 1'b1;
          p_addr[i]  = $urandom;
          p_wdata[i] = {$urandom, $urandom};
          p_wen[i]   = 1'($urandom);
          p_wmask[i] = 8'($urandom);
          p_size[i]  = 3'($urandom);
        end
      end
      p = int'($urandom % NP);
      rv = 1'b0;
      dst = 5'(p);
      if (m_cnt[p] > 0 && ($urandom % 2 == 1)) begin
        rv = 1'b1;
      end else if ($urandom % 8 == 0) begin
        rv = 1'b1;
        dst = 5'(4 + ($urandom % 28));
      end
      step(pend, 1'($urandom % 4 != 0), rv, dst, 4'($urandom), acc);
      if (acc >= 0) pend[acc] = 1'b0;
    end

    // Second instance: SRCID_BASE=4, three ports.
    @(negedge clk);
    b_up_req_valid = 3'b010;
    b_dn_req_ready = 1'b1;
    #1;
    checkOutput("b srcid single", 64'(b_dn_req_srcid), 64'd5);
    checkOutput("b ready single", 64'(b_up_req_ready), 64'b010);
    @(negedge clk);
    b_up_req_valid = 3'b101;
    #1;
    checkOutput("b srcid after port1", 64'(b_dn_req_srcid), 64'd6);
    checkOutput("b ready after port1", 64'(b_up_req_ready), 64'b100);
    @(negedge clk);
    b_up_req_valid = 3'b001;
    #1;
    checkOutput("b srcid wrap", 64'(b_dn_req_srcid), 64'd4);
    @(negedge clk);
    b_up_req_valid = 3'b000;
    b_dn_resp_valid = 1'b1;
    b_dn_resp_dstid = 5'd6;
    b_dn_resp_rdata = 64'hDEAD_BEEF;
    b_up_resp_ready = 3'b111;
    #1;
    checkOutput("b resp dst6 valid", 64'(b_up_resp_valid), 64'b100);
    checkOutput("b resp dst6 rdata", b_up_resp_rdata[128 +: 64], 64'hDEAD_BEEF);
    checkOutput("b resp dst6 ready", 64'(b_dn_resp_ready), 64'd1);
    b_up_resp_ready = 3'b011;
    #1;
    checkOutput("b resp dst6 backpressure", 64'(b_dn_resp_ready), 64'd0);
    b_dn_resp_dstid = 5'd9;
    #1;
    checkOutput("b resp dst9 valid", 64'(b_up_resp_valid), 64'd0);
    checkOutput("b resp dst9 ready", 64'(b_dn_resp_ready), 64'd1);
    b_dn_resp_dstid = 5'd3;
    #1;
    checkOutput("b resp dst3 valid", 64'(b_up_resp_valid), 64'd0);
    checkOutput("b resp dst3 ready", 64'(b_dn_resp_ready), 64'd1);
    b_dn_resp_dstid = 5'd4;
    #1;
    checkOutput("b resp dst4 valid", 64'(b_up_resp_valid), 64'b001);
    checkOutput("b resp dst4 ready", 64'(b_dn_resp_ready), 64'd1);
    @(negedge clk);
    b_dn_resp_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
